mul_seq_unit: RTL and testbench

//  Multi-cycle radix-2 shift-add multiplier for the EX stage. Consumes LD-stage operands
//  (data_out_1_ld / data_out_2_ld) and drives mul_out and is_done_mul into the CPU.
//  The CPU freezes all pipeline registers while is_done is low. EX captures out on the

---
 rtl/mul_pkg.sv | 10 +
 rtl/mul_step.sv | 23 ++
 rtl/mul_seq_unit.sv | 116 +++++++++++
 tb/tb_mul_seq_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state encoding and defaults for the sequential multiplier
package mul_pkg;

    localparam logic [1:0] MUL_IDLE = 2'd0;
    localparam logic [1:0] MUL_RUN  = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/mul_step.sv
// rtl/mul_step.sv - one radix-2 shift-add iteration of the multiplier datapath
module mul_step
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic [2*WIDTH-1:0] mcand_nxt,
    output logic [WIDTH-1:0]   mplier_nxt
);

    // Add the shifted multiplicand when the current multiplier bit is set, then shift both.
    // The accumulator is 2*WIDTH wide, which always holds the full product, so no carry out.
    always_comb begin
        acc_nxt    = mplier[0] ? (acc + mcand) : acc;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
    end

endmodule

// File: rtl/mul_seq_unit.sv
// rtl/mul_seq_unit.sv - multi-cycle shift-add multiplier with is_done pipeline-freeze output
module mul_seq_unit
    import mul_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    output logic [WIDTH-1:0]   out,
    output logic [2*WIDTH-1:0] out_full,
    output logic               overflow,
    output logic               busy,
    output logic               is_done
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]         state_q,    state_d;
    logic [2*WIDTH-1:0] acc_q,      acc_d;
    logic [2*WIDTH-1:0] mcand_q,    mcand_d;
    logic [WIDTH-1:0]   mplier_q,   mplier_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [2*WIDTH-1:0] out_full_q, out_full_d;

    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] step_mcand;
    logic [WIDTH-1:0]   step_mplier;
    logic               accept;
    logic               run_last;

    mul_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc        (acc_q),
        .mcand      (mcand_q),
        .mplier     (mplier_q),
        .acc_nxt    (step_acc),
        .mcand_nxt  (step_mcand),
        .mplier_nxt (step_mplier)
    );

    // A new operation is accepted only between operations; the last RUN edge is either the
    // final bit position or, with early exit, the point where no multiplier bits remain.
    always_comb begin
        accept   = ((state_q == MUL_IDLE) || (state_q == MUL_DONE)) && start;
        run_last = (cnt_q == CNT_LAST) || (EARLY_EXIT && (step_mplier == '0));
    end

    // State and datapath registers; reset aborts any operation and clears the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MUL_IDLE;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            out_full_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            out_full_q <= out_full_d;
        end
    end

    // Next-state logic: DONE falls back to IDLE unless a held start chains another op.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: if (start) state_d = MUL_RUN;
            MUL_RUN:  if (run_last) state_d = MUL_DONE;
            MUL_DONE: state_d = start ? MUL_RUN : MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    // Datapath next values; the visible result is only updated on the RUN->DONE edge.
    always_comb begin
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        out_full_d = out_full_q;
        if (accept) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, in1};
            mplier_d = in2;
            cnt_d    = '0;
        end else if (state_q == MUL_RUN) begin
            acc_d    = step_acc;
            mcand_d  = step_mcand;
            mplier_d = step_mplier;
            cnt_d    = cnt_q + 1'b1;
            if (run_last) begin
                out_full_d = step_acc;
            end
        end
    end

    // Outputs: is_done drops combinationally with start so the pipeline freezes with no bubble.
    always_comb begin
        busy     = (state_q == MUL_RUN);
        is_done  = ((state_q == MUL_IDLE) && !start) || (state_q == MUL_DONE);
        out_full = out_full_q;
        out      = out_full_q[WIDTH-1:0];
        overflow = |out_full_q[2*WIDTH-1:WIDTH];
    end

endmodule

// File: tb/tb_mul_seq_unit.sv
// tb/tb_mul_seq_unit.sv - randomized self-checking bench for mul_seq_unit in both exit modes
module tb_mul_seq_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_v    [2];
    logic [7:0]  in1_v      [2];
    logic [7:0]  in2_v      [2];
    logic [7:0]  out_v      [2];
    logic [15:0] out_full_v [2];
    logic        overflow_v [2];
    logic        busy_v     [2];
    logic        is_done_v  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_seq_unit #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .in1(in1_v[0]), .in2(in2_v[0]),
        .out(out_v[0]), .out_full(out_full_v[0]), .overflow(overflow_v[0]),
        .busy(busy_v[0]), .is_done(is_done_v[0])
    );

    mul_seq_unit #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .in1(in1_v[1]), .in2(in2_v[1]),
        .out(out_v[1]), .out_full(out_full_v[1]), .overflow(overflow_v[1]),
        .busy(busy_v[1]), .is_done(is_done_v[1])
    );

    // Expected number of RUN cycles: full width, or bit-length of the multiplier (min 1).
    function automatic int ref_lat(input int m, input logic [7:0] b);
        int h;
        if (m == 0) return 8;
        h = 0;
        for (int i = 0; i < 8; i++) if (b[i]) h = i + 1;
        return (h < 1) ? 1 : h;
    endfunction

    // Launches one op on instance m, counts RUN cycles until is_done, returns the product.
    task automatic run_op(input int m, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic [15:0] full);
        int guard;
        @(negedge clk);
        in1_v[m] = a; in2_v[m] = b; start_v[m] = 1'b1;
        #1;
        checks++;
        if (is_done_v[m] !== 1'b0) begin
            errors++;
            $display("FAIL is_done_drop m=%0d got=%b want=0", m, is_done_v[m]);
        end
        @(negedge clk);
        start_v[m] = 1'b0;
        lat = 0; guard = 0;
        while (is_done_v[m] !== 1'b1 && guard < 40) begin
            checks++;
            if (busy_v[m] !== 1'b1) begin
                errors++;
                $display("FAIL busy_in_run m=%0d got=%b want=1", m, busy_v[m]);
            end
            lat++; guard++;
            @(negedge clk);
        end
        if (guard >= 40) begin
            checks++; errors++;
            $display("FAIL timeout m=%0d a=%0d b=%0d got=no_done want=done", m, a, b);
        end
        full = out_full_v[m];
    endtask

    // Checks one finished op against arithmetic product and latency formula.
    task automatic check_op(input string name, input int m, input logic [7:0] a,
                            input logic [7:0] b, input int lat, input logic [15:0] full);
        logic [15:0] exp_full;
        int          exp_lat;
        exp_full = 16'(a) * 16'(b);
        exp_lat  = ref_lat(m, b);
        checks++;
        if (full !== exp_full) begin
            errors++;
            $display("FAIL %s_full m=%0d a=%0d b=%0d got=%h want=%h", name, m, a, b, full, exp_full);
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_lat m=%0d a=%0d b=%0d got=%0d want=%0d", name, m, a, b, lat, exp_lat);
        end
        checks++;
        if (out_v[m] !== exp_full[7:0] || overflow_v[m] !== (exp_full[15:8] != 8'h00)) begin
            errors++;
            $display("FAIL %s_out m=%0d got=%h/%b want=%h/%b", name, m, out_v[m], overflow_v[m],
                     exp_full[7:0], exp_full[15:8] != 8'h00);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (out_v[m] !== 8'h00 || out_full_v[m] !== 16'h0000 || overflow_v[m] !== 1'b0 ||
                busy_v[m] !== 1'b0 || is_done_v[m] !== 1'b1) begin
                errors++;
                $display("FAIL reset m=%0d got out=%h full=%h ovf=%b busy=%b done=%b want 00/0000/0/0/1",
                         m, out_v[m], out_full_v[m], overflow_v[m], busy_v[m], is_done_v[m]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat; logic [15:0] full;
        run_op(0, 8'd5, 8'd7, lat, full);
        check_op("basic", 0, 8'd5, 8'd7, lat, full);
        checks++;
        if (full !== 16'h0023) begin
            errors++;
            $display("FAIL basic_const got=%h want=0023", full);
        end
        run_op(1, 8'd5, 8'd7, lat, full);
        check_op("basic_ee", 1, 8'd5, 8'd7, lat, full);
    endtask

    task automatic test_max();
        int lat; logic [15:0] full;
        for (int m = 0; m < 2; m++) begin
            run_op(m, 8'd255, 8'd255, lat, full);
            check_op("max", m, 8'd255, 8'd255, lat, full);
            checks++;
            if (full !== 16'hFE01 || out_v[m] !== 8'h01 || overflow_v[m] !== 1'b1 || lat != 8) begin
                errors++;
                $display("FAIL max_const m=%0d got=%h/%h/%b/%0d want=FE01/01/1/8",
                         m, full, out_v[m], overflow_v[m], lat);
            end
        end
    endtask

    task automatic test_early();
        int lat; logic [15:0] full;
        run_op(1, 8'd9, 8'd3, lat, full);
        checks++;
        if (out_v[1] !== 8'h1B || lat != 2) begin
            errors++;
            $display("FAIL early_9x3 got=%h/%0d want=1b/2", out_v[1], lat);
        end
        run_op(1, 8'd200, 8'd0, lat, full);
        checks++;
        if (full !== 16'h0000 || lat != 1) begin
            errors++;
            $display("FAIL early_zero got=%h/%0d want=0000/1", full, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat; int guard;
        @(negedge clk);
        in1_v[0] = 8'd6; in2_v[0] = 8'd6; start_v[0] = 1'b1;
        repeat (3) @(negedge clk);
        in1_v[0] = 8'd2; in2_v[0] = 8'd2;
        guard = 0;
        while (is_done_v[0] !== 1'b1 && guard < 40) begin guard++; @(negedge clk); end
        checks++;
        if (out_v[0] !== 8'h24 || guard >= 40) begin
            errors++;
            $display("FAIL b2b_first got=%h want=24", out_v[0]);
        end
        @(negedge clk);
        checks++;
        if (busy_v[0] !== 1'b1 || is_done_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_idle got busy=%b done=%b want 1/0", busy_v[0], is_done_v[0]);
        end
        start_v[0] = 1'b0;
        lat = 0; guard = 0;
        while (is_done_v[0] !== 1'b1 && guard < 40) begin lat++; guard++; @(negedge clk); end
        checks++;
        if (out_v[0] !== 8'h04 || lat != 8) begin
            errors++;
            $display("FAIL b2b_second got=%h/%0d want=04/8", out_v[0], lat);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat; logic [15:0] full;
        @(negedge clk);
        in1_v[0] = 8'd7; in2_v[0] = 8'd9; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy_v[0] !== 1'b0 || is_done_v[0] !== 1'b1 || out_v[0] !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_run got busy=%b done=%b out=%h want 0/1/00",
                     busy_v[0], is_done_v[0], out_v[0]);
        end
        run_op(0, 8'd3, 8'd4, lat, full);
        check_op("after_rst", 0, 8'd3, 8'd4, lat, full);
    endtask

    task automatic test_random();
        int lat; logic [15:0] full; logic [7:0] a, b;
        for (int n = 0; n < 1000; n++) begin
            for (int m = 0; m < 2; m++) begin
                a = 8'($urandom);
                b = 8'($urandom);
                if ($urandom_range(3) == 0) b = b >> $urandom_range(7);
                run_op(m, a, b, lat, full);
                check_op("rand", m, a, b, lat, full);
            end
        end
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            start_v[m] = 1'b0; in1_v[m] = '0; in2_v[m] = '0;
        end
        test_reset();
        test_basic();
        test_max();
        test_early();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
